// File: rtl/bcd_display_scanner_if.sv
// Digit inputs and display outputs of the multiplexed seven-segment scanner.
// The master side supplies digit codes; the slave side (the scanner) drives the display.
interface bcd_display_scanner_if;
  logic [3:0] D5_in;
  logic [3:0] D4_in;
  logic [3:0] D3_in;
  logic [3:0] D2_in;
  logic [3:0] D1_in;
  logic [6:0] seg_out;
  logic [4:0] anode_out;
  logic [2:0] digit_idx;
  logic       frame_start;

  modport master (
    output D5_in, D4_in, D3_in, D2_in, D1_in,
    input  seg_out, anode_out, digit_idx, frame_start
  );

  modport slave (
    input  D5_in, D4_in, D3_in, D2_in, D1_in,
    output seg_out, anode_out, digit_idx, frame_start
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode 5-digit seven-segment scanner with per-frame digit snapshot.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits D5..D2.
module bcd_display_scanner #(
  parameter int SCAN_DIV = 2000
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  bcd_display_scanner_if.slave  dif
);

  localparam int            PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0]   presc_r;
  logic [2:0]      idx_r;
  logic [4:0]      anode_r;
  logic [6:0]      seg_r;
  logic            frame_r;
  logic [4:0][3:0] snap_r;

  logic            tick;
  logic            wrap;
  logic [2:0]      idx_nxt;
  logic [4:0][3:0] src;
  logic [3:0]      sel;
  logic [6:0]      seg_nxt;
  logic [4:0]      anode_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A slot is blank when its digit and every more significant digit are zero; D1 never blanks.
  function automatic logic lz_blank(input logic [4:0][3:0] d, input logic [2:0] idx);
    logic run_zero;
    logic hit;
    run_zero = 1'b1;
    hit      = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      run_zero = run_zero && (d[i] == 4'd0);
      if (3'(i) == idx) hit = run_zero;
    end
    return hit;
  endfunction
`endif

  assign tick = (presc_r == PMAX);
  assign wrap = (idx_r == 3'd4);

  always_comb begin
    idx_nxt = wrap ? 3'd0 : idx_r + 3'd1;
    // At frame start the slot-0 digit comes straight from the inputs being captured.
    src     = wrap ? {dif.D5_in, dif.D4_in, dif.D3_in, dif.D2_in, dif.D1_in} : snap_r;
    case (idx_nxt)
      3'd1:    sel = src[1];
      3'd2:    sel = src[2];
      3'd3:    sel = src[3];
      3'd4:    sel = src[4];
      default: sel = src[0];
    endcase
    seg_nxt   = seg_decode(sel);
    anode_nxt = ~(5'b00001 << idx_nxt);
`ifdef LEADING_ZERO_BLANK_EN
    if (lz_blank(src, idx_nxt)) begin
      seg_nxt   = 7'h7F;
      anode_nxt = 5'b11111;
    end
`endif
  end

  // Stage p0: prescaler, slot advance and registered display outputs
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      presc_r <= '0;
      idx_r   <= 3'd4;
      anode_r <= 5'b11111;
      seg_r   <= 7'h7F;
      frame_r <= 1'b0;
      snap_r  <= '0;
    end else begin
      presc_r <= tick ? '0 : presc_r + PW'(1);
      frame_r <= tick && wrap;
      if (tick) begin
        idx_r   <= idx_nxt;
        seg_r   <= seg_nxt;
        anode_r <= anode_nxt;
        if (wrap) snap_r <= {dif.D5_in, dif.D4_in, dif.D3_in, dif.D2_in, dif.D1_in};
      end
    end
  end

  assign dif.seg_out     = seg_r;
  assign dif.anode_out   = anode_r;
  assign dif.digit_idx   = idx_r;
  assign dif.frame_start = frame_r;

endmodule
